// File: rtl/data_memory.sv
`default_nettype none
// ============================================================================
// Module      : data_memory
// Description : Word-organised data RAM with byte-enable stores, a
//               request/valid handshake, programmable access latency and
//               out-of-range address flagging.
// Revision    : 1.0 - initial release
// ============================================================================
module data_memory #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        request,
    input  logic        we_re,
    input  logic [3:0]  mask,
    input  logic [31:0] address,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        valid,
    output logic [31:0] load_data,
    output logic        addr_err
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_cw = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_wait = 1'b1;
    localparam logic [31:0] c_limit = 32'(DEPTH * 4);

    logic [0:0]      r_state;
    logic [0:0]      w_state_nxt;
    logic [c_cw-1:0] r_cnt;
    logic            r_we;
    logic [3:0]      r_mask;
    logic [31:0]     r_addr;
    logic [31:0]     r_data;
    logic            r_valid;
    logic [31:0]     r_load;
    logic            r_err;
    logic [31:0]     r_mem [DEPTH];

    logic            w_done;
    logic            w_oob;
    logic            w_wr_en;
    logic [c_aw-1:0] w_idx;

    assign w_oob   = (r_addr >= c_limit);
    assign w_idx   = r_addr[c_aw+1:2];
    // Gating with rst keeps a reset coincident with the access edge from writing.
    assign w_wr_en = w_done && r_we && !w_oob && !rst;

    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (request) begin
                    w_state_nxt = c_st_wait;
                end
            end
            c_st_wait: begin
                if (r_cnt == '0) begin
                    w_state_nxt = c_st_idle;
                    w_done      = 1'b1;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_mask  <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_load  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= w_done;
            r_err   <= w_done && w_oob;
            if (r_state == c_st_idle && request) begin
                r_we   <= we_re;
                r_mask <= mask;
                r_addr <= address;
                r_data <= store_data;
                r_cnt  <= c_cw'(LATENCY - 1);
            end else if (r_state == c_st_wait && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_done) begin
                r_load <= (r_we || w_oob) ? 32'h0 : r_mem[w_idx];
            end
        end
    end

    // RAM array carries no reset so its contents survive rst.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (r_mask[i]) begin
                    r_mem[w_idx][8*i +: 8] <= r_data[8*i +: 8];
                end
            end
        end
    end

    assign busy      = (r_state == c_st_wait);
    assign valid     = r_valid;
    assign load_data = r_load;
    assign addr_err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_data_memory.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_memory
// Description : Self-checking bench for data_memory at LATENCY=1 and LATENCY=3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_memory;

    typedef struct {
        logic        we;
        logic [3:0]  mask;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst   [2];
    logic        req   [2];
    logic        we    [2];
    logic [3:0]  msk   [2];
    logic [31:0] adr   [2];
    logic [31:0] sd    [2];
    logic        busy  [2];
    logic        valid [2];
    logic [31:0] ld    [2];
    logic        aerr  [2];

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    sb_t  q0[$];
    sb_t  q1[$];
    vec_t tbl [14];
    logic [31:0] mdl [8];

    data_memory #(.DEPTH(256), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst[0]), .request(req[0]), .we_re(we[0]), .mask(msk[0]),
        .address(adr[0]), .store_data(sd[0]), .busy(busy[0]), .valid(valid[0]),
        .load_data(ld[0]), .addr_err(aerr[0])
    );

    data_memory #(.DEPTH(256), .LATENCY(3)) u_dut3 (
        .clk(clk), .rst(rst[1]), .request(req[1]), .we_re(we[1]), .mask(msk[1]),
        .address(adr[1]), .store_data(sd[1]), .busy(busy[1]), .valid(valid[1]),
        .load_data(ld[1]), .addr_err(aerr[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic int lat(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic push(input int d, input logic [31:0] data, input logic err, input int c);
        sb_t e;
        e.data = data;
        e.err  = err;
        e.cyc  = c;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic mon(input int d);
        sb_t e;
        int  n;
        n = (d == 0) ? q0.size() : q1.size();
        if (valid[d] === 1'b1) begin
            if (n == 0) begin
                chk($sformatf("unexpected_valid_dut%0d", d), 32'(valid[d]), 32'h0);
            end else begin
                e = (d == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("load_data_dut%0d", d), ld[d], e.data);
                chk($sformatf("addr_err_dut%0d", d), 32'(aerr[d]), 32'(e.err));
                chk($sformatf("latency_dut%0d", d), cyc, e.cyc);
            end
        end else begin
            chk($sformatf("addr_err_idle_dut%0d", d), 32'(aerr[d]), 32'h0);
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    task automatic wait_idle(input int d);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy[d] !== 1'b0 && n < 100);
        if (busy[d] !== 1'b0) chk("idle_timeout", 32'(busy[d]), 32'h0);
    endtask

    task automatic drive(input int d, input vec_t v);
        req[d] = 1'b1;
        we[d]  = v.we;
        msk[d] = v.mask;
        adr[d] = v.addr;
        sd[d]  = v.data;
    endtask

    task automatic send(input int d, input vec_t v);
        wait_idle(d);
        drive(d, v);
        push(d, v.exp_data, v.exp_err, cyc + lat(d) + 1);
        @(negedge clk);
        req[d] = 1'b0;
    endtask

    task automatic drain(input int d);
        int n = 0;
        while (((d == 0) ? q0.size() : q1.size()) > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("drain_dut%0d", d), (d == 0) ? q0.size() : q1.size(), 32'h0);
        if (d == 0) q0.delete();
        else        q1.delete();
    endtask

    function automatic vec_t mk(input logic w, input logic [3:0] m, input logic [31:0] a,
                                input logic [31:0] dt, input logic [31:0] ex, input logic er);
        vec_t v;
        v.we = w; v.mask = m; v.addr = a; v.data = dt; v.exp_data = ex; v.exp_err = er;
        return v;
    endfunction

    initial begin
        int   nb;
        int   prev;
        int   w;
        vec_t v;

        tbl[0]  = '{1'b1, 4'hF, 32'h010, 32'hDEADBEEF, 32'h0,        1'b0};
        tbl[1]  = '{1'b0, 4'h0, 32'h010, 32'h0,        32'hDEADBEEF, 1'b0};
        tbl[2]  = '{1'b1, 4'h4, 32'h010, 32'h00AA0000, 32'h0,        1'b0};
        tbl[3]  = '{1'b0, 4'h0, 32'h010, 32'h0,        32'hDEAABEEF, 1'b0};
        tbl[4]  = '{1'b1, 4'h0, 32'h010, 32'hFFFFFFFF, 32'h0,        1'b0};
        tbl[5]  = '{1'b0, 4'hF, 32'h013, 32'h0,        32'hDEAABEEF, 1'b0};
        tbl[6]  = '{1'b1, 4'hF, 32'h000, 32'hCAFEF00D, 32'h0,        1'b0};
        tbl[7]  = '{1'b1, 4'hF, 32'h3FC, 32'h12345678, 32'h0,        1'b0};
        tbl[8]  = '{1'b0, 4'h0, 32'h3FC, 32'h0,        32'h12345678, 1'b0};
        tbl[9]  = '{1'b1, 4'hF, 32'h400, 32'hFFFFFFFF, 32'h0,        1'b1};
        tbl[10] = '{1'b0, 4'h0, 32'h400, 32'h0,        32'h0,        1'b1};
        tbl[11] = '{1'b0, 4'h0, 32'h000, 32'h0,        32'hCAFEF00D, 1'b0};
        tbl[12] = '{1'b1, 4'h3, 32'h3FC, 32'h0000AAAA, 32'h0,        1'b0};
        tbl[13] = '{1'b0, 4'h0, 32'h3FC, 32'h0,        32'h1234AAAA, 1'b0};

        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; req[d] = 1'b0; we[d] = 1'b0;
            msk[d] = 4'h0; adr[d] = 32'h0; sd[d] = 32'h0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset_busy",  32'(busy[d]),  32'h0);
            chk("reset_valid", 32'(valid[d]), 32'h0);
            chk("reset_load",  ld[d],         32'h0);
            chk("reset_err",   32'(aerr[d]),  32'h0);
        end
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        // Vector table on the single-cycle instance, issued back to back.
        for (int i = 0; i < 14; i++) send(0, tbl[i]);
        drain(0);

        // Requests presented while busy must be ignored.
        send(1, mk(1'b1, 4'hF, 32'h40, 32'hA5A5A5A5, 32'h0, 1'b0));
        send(1, mk(1'b1, 4'hF, 32'h44, 32'h5A5A5A5A, 32'h0, 1'b0));
        wait_idle(1);
        drive(1, mk(1'b0, 4'h0, 32'h40, 32'h0, 32'h0, 1'b0));
        push(1, 32'hA5A5A5A5, 1'b0, cyc + 4);
        nb = 0;
        for (int t = 1; t <= 4; t++) begin
            @(negedge clk);
            if (busy[1] === 1'b1) nb++;
            if (t == 1) drive(1, mk(1'b1, 4'hF, 32'h44, 32'hFFFFFFFF, 32'h0, 1'b0));
            if (t == 3) req[1] = 1'b0;
        end
        chk("busy_cycles", nb, 32'd3);
        send(1, mk(1'b0, 4'h0, 32'h44, 32'h0, 32'h5A5A5A5A, 1'b0));
        drain(1);

        // Reset during WAIT drops the store.
        send(1, mk(1'b1, 4'hF, 32'h20, 32'h11111111, 32'h0, 1'b0));
        wait_idle(1);
        drive(1, mk(1'b1, 4'hF, 32'h20, 32'h22222222, 32'h0, 1'b0));
        @(negedge clk);
        req[1] = 1'b0;
        chk("busy_in_wait", 32'(busy[1]), 32'h1);
        @(negedge clk);
        rst[1] = 1'b1;
        #1;
        chk("midrst_busy",  32'(busy[1]),  32'h0);
        chk("midrst_valid", 32'(valid[1]), 32'h0);
        chk("midrst_load",  ld[1],         32'h0);
        @(negedge clk);
        rst[1] = 1'b0;
        repeat (6) @(negedge clk);
        send(1, mk(1'b0, 4'h0, 32'h20, 32'h0, 32'h11111111, 1'b0));
        drain(1);

        // Request held high, alternating store/load against a reference model.
        prev = -1;
        for (int j = 0; j < 24; j++) begin
            wait_idle(1);
            if (j < 8) begin
                v = mk(1'b1, 4'hF, 32'(j * 4), $urandom, 32'h0, 1'b0);
                mdl[j] = v.data;
            end else if (j % 2 == 0) begin
                w = $urandom_range(0, 7);
                v = mk(1'b1, 4'($urandom_range(0, 15)), 32'(w * 4), $urandom, 32'h0, 1'b0);
                for (int b = 0; b < 4; b++)
                    if (v.mask[b]) mdl[w][8*b +: 8] = v.data[8*b +: 8];
            end else begin
                w = $urandom_range(0, 7);
                v = mk(1'b0, 4'h0, 32'(w * 4) | 32'($urandom_range(0, 3)), 32'h0, 32'h0, 1'b0);
                v.exp_data = mdl[w];
            end
            drive(1, v);
            push(1, v.exp_data, 1'b0, cyc + 4);
            if (prev >= 0) chk("accept_interval", cyc - prev, 32'd4);
            prev = cyc;
        end
        @(negedge clk);
        req[1] = 1'b0;
        drain(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
